// File: rtl/circuit_eval_pipe.sv
// circuit_eval_pipe: two-stage valid/ready pipeline evaluating a per-bit 3-input boolean function
// Latency: operands captured in S1 on one edge, result registered in S2 on the next edge
// Backpressure: each stage reloads when its downstream frees; in_ready drops only when both stages are full and out_ready=0
//
// Ports:
//   clk, rst              single clock, synchronous active-high reset
//   in_valid/in_ready     operand handshake (a, b, c, mode sampled on transfer)
//   out_valid/out_ready   result handshake (x)
//   cnt_clr, match_cnt    saturating count of all-ones results transferred out, with synchronous clear
//   popcnt                number of ones in x, present only when CIRCUIT_POPCNT_EN is defined
//
// Optional feature macro: CIRCUIT_POPCNT_EN

module circuit_eval_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] x,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] match_cnt
`ifdef CIRCUIT_POPCNT_EN
  ,
  output logic [$clog2(WIDTH+1)-1:0] popcnt
`endif
);

  // Stage S1: operands + mode
  logic             r_s1_vld;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_c;
  logic [1:0]       r_mode;

  // Stage S2: result
  logic             r_s2_vld;
  logic [WIDTH-1:0] r_x;

  logic [CNT_W-1:0] r_cnt;

  logic             w_s2_load;
  logic             w_s1_load;
  logic             w_out_xfer;
  logic             w_ones;
  logic             w_cnt_max;
  logic [WIDTH-1:0] w_res;

  // S2 can take new data when empty or when its content leaves this cycle;
  // S1 can take new data when empty or when it hands off to S2.
  assign w_s2_load  = ~r_s2_vld | out_ready;
  assign w_s1_load  = ~r_s1_vld | w_s2_load;
  assign w_out_xfer = r_s2_vld & out_ready;
  assign w_ones     = &r_x;
  assign w_cnt_max  = &r_cnt;

  // Reset is synchronous, so gate the handshake outputs with rst directly:
  // the block must look empty and ready for the whole reset cycle.
  assign in_ready  = rst | w_s1_load;
  assign out_valid = r_s2_vld & ~rst;
  assign x         = r_x;
  assign match_cnt = r_cnt;

  always_comb begin
    w_res = '0;
    unique case (r_mode)
      2'b00: w_res = r_a & ~(r_b ^ r_c);
      2'b01: w_res = ~(r_a & ~(r_b ^ r_c));
      2'b10: w_res = r_a ^ r_b ^ r_c;
      2'b11: w_res = (r_a & r_b) | (r_a & r_c) | (r_b & r_c);
      default: w_res = '0;
    endcase
  end

  // Control, result and counter state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vld <= 1'b0;
      r_s2_vld <= 1'b0;
      r_x      <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_s1_load) begin
        r_s1_vld <= in_valid;
      end
      if (w_s2_load) begin
        r_s2_vld <= r_s1_vld;
        if (r_s1_vld) begin
          r_x <= w_res;
        end
      end
      // Clear wins over a same-cycle increment; the count sticks at its maximum.
      if (cnt_clr) begin
        r_cnt <= '0;
      end else if (w_out_xfer && w_ones && !w_cnt_max) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Operand registers carry no reset: they are qualified by r_s1_vld.
  always_ff @(posedge clk) begin
    if (w_s1_load && in_valid) begin
      r_a    <= a;
      r_b    <= b;
      r_c    <= c;
      r_mode <= mode;
    end
  end

`ifdef CIRCUIT_POPCNT_EN
  localparam int PC_W = $clog2(WIDTH+1);

  logic [PC_W-1:0] r_popcnt;

  function automatic logic [PC_W-1:0] f_popcnt(input logic [WIDTH-1:0] v);
    logic [PC_W-1:0] n;
    n = '0;
    for (int i = 0; i < WIDTH; i++) begin
      n = n + PC_W'(v[i]);
    end
    return n;
  endfunction

  // Computed from the same next-state value as r_x so the two stay aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_popcnt <= '0;
    end else if (w_s2_load && r_s1_vld) begin
      r_popcnt <= f_popcnt(w_res);
    end
  end

  assign popcnt = r_popcnt;
`else
  // No popcount path: x alone carries the result.
`endif

endmodule

// File: tb/tb_circuit_eval_pipe.sv
module tb_circuit_eval_pipe;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] x;
  logic             cnt_clr;
  logic [CNT_W-1:0] match_cnt;
`ifdef CIRCUIT_POPCNT_EN
  logic [$clog2(WIDTH+1)-1:0] popcnt;
`endif

  int ntot  = 0;
  int npass = 0;
  int nfail = 0;

  circuit_eval_pipe #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .c        (c),
    .mode     (mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .x        (x),
    .cnt_clr  (cnt_clr),
    .match_cnt(match_cnt)
`ifdef CIRCUIT_POPCNT_EN
    ,
    .popcnt   (popcnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntot = ntot + 1;
    assert (obs === exp) npass = npass + 1;
    else begin
      nfail = nfail + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 2 time units after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [1:0] m,
                       input logic [7:0] aa, input logic [7:0] bb, input logic [7:0] cc);
    in_valid = v;
    mode     = m;
    a        = aa;
    b        = bb;
    c        = cc;
  endtask

  initial begin
    rst       = 1'b1;
    out_ready = 1'b1;
    cnt_clr   = 1'b0;
    drive(1'b0, 2'b00, 8'h00, 8'h00, 8'h00);
    tick();
    tick();
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_x", x, 8'h00);
    chk("rst_match_cnt", match_cnt, 4'h0);
`ifdef CIRCUIT_POPCNT_EN
    chk("rst_popcnt", popcnt, 4'd0);
`endif
    rst = 1'b0;
    tick();

    // mode 00 pair, 2-cycle latency, one all-ones result
    drive(1'b1, 2'b00, 8'hFF, 8'h0F, 8'h0F);
    tick();
    chk("lat_not_yet", out_valid, 1'b0);
    drive(1'b1, 2'b00, 8'hFF, 8'h0F, 8'h00);
    tick();
    in_valid = 1'b0;
    chk("m00_first_vld", out_valid, 1'b1);
    chk("m00_first_x", x, 8'hFF);
    chk("m00_cnt_before", match_cnt, 4'h0);
    tick();
    chk("m00_second_x", x, 8'hF0);
    chk("m00_cnt_one", match_cnt, 4'h1);
    tick();
    chk("m00_drained", out_valid, 1'b0);
    chk("m00_cnt_keep", match_cnt, 4'h1);

    // xor, majority, mode 01 back to back
    drive(1'b1, 2'b10, 8'hF0, 8'hCC, 8'hAA);
    tick();
    drive(1'b1, 2'b11, 8'hF0, 8'hCC, 8'hAA);
    tick();
    chk("xor_x", x, 8'h96);
    drive(1'b1, 2'b01, 8'hFF, 8'h0F, 8'h0F);
    tick();
    in_valid = 1'b0;
    chk("maj_x", x, 8'hE8);
`ifdef CIRCUIT_POPCNT_EN
    chk("maj_popcnt", popcnt, 4'd4);
`endif
    tick();
    chk("m01_x", x, 8'h00);
    chk("m01_vld", out_valid, 1'b1);
    tick();
    chk("m01_drained", out_valid, 1'b0);

    // backpressure: 4 sets, stall from the second result
    drive(1'b1, 2'b10, 8'h11, 8'h00, 8'h00);
    tick();
    drive(1'b1, 2'b10, 8'h22, 8'h00, 8'h00);
    tick();
    chk("bp_r0", x, 8'h11);
    drive(1'b1, 2'b10, 8'h33, 8'h00, 8'h00);
    tick();
    out_ready = 1'b0;
    drive(1'b1, 2'b10, 8'h44, 8'h00, 8'h00);
    #1;
    chk("bp_r1", x, 8'h22);
    chk("bp_full_in_ready", in_ready, 1'b0);
    tick();
    chk("bp_hold_x1", x, 8'h22);
    chk("bp_hold_vld1", out_valid, 1'b1);
    tick();
    chk("bp_hold_x2", x, 8'h22);
    chk("bp_hold_rdy2", in_ready, 1'b0);
    out_ready = 1'b1;
    #1;
    chk("bp_release_rdy", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("bp_r2", x, 8'h33);
    tick();
    chk("bp_r3", x, 8'h44);
    chk("bp_r3_vld", out_valid, 1'b1);
    tick();
    chk("bp_drained", out_valid, 1'b0);

    // saturation: clear, then 20 all-ones results
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr_cnt", match_cnt, 4'h0);
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 2'b00, 8'hFF, 8'h00, 8'h00);
      tick();
      if (i == 15) chk("stream_cnt14", match_cnt, 4'hE);
    end
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("sat_cnt", match_cnt, 4'hF);

    // clear beats a same-cycle all-ones transfer
    drive(1'b1, 2'b00, 8'hFF, 8'h00, 8'h00);
    tick();
    in_valid = 1'b0;
    tick();
    chk("clrx_x", x, 8'hFF);
`ifdef CIRCUIT_POPCNT_EN
    chk("ff_popcnt", popcnt, 4'd8);
`endif
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clrx_cnt", match_cnt, 4'h0);

    // one all-ones transfer so reset has a count to clear
    drive(1'b1, 2'b00, 8'hFF, 8'h00, 8'h00);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("pre_rst_cnt", match_cnt, 4'h1);

    // fill both stages, then reset with live inputs
    out_ready = 1'b0;
    drive(1'b1, 2'b10, 8'h55, 8'h00, 8'h00);
    tick();
    drive(1'b1, 2'b10, 8'h66, 8'h00, 8'h00);
    tick();
    drive(1'b1, 2'b10, 8'h77, 8'h00, 8'h00);
    #1;
    chk("full_vld", out_valid, 1'b1);
    chk("full_in_ready", in_ready, 1'b0);
    rst = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("in_rst_vld", out_valid, 1'b0);
    chk("in_rst_rdy", in_ready, 1'b1);
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("post_rst_vld", out_valid, 1'b0);
    chk("post_rst_cnt", match_cnt, 4'h0);
    chk("post_rst_x", x, 8'h00);
    chk("post_rst_rdy", in_ready, 1'b1);
`ifdef CIRCUIT_POPCNT_EN
    chk("post_rst_popcnt", popcnt, 4'd0);
`endif
    tick();
    chk("discarded_vld", out_valid, 1'b0);
    drive(1'b1, 2'b11, 8'hF0, 8'hCC, 8'hAA);
    tick();
    in_valid = 1'b0;
    chk("after_rst_lat", out_valid, 1'b0);
    tick();
    chk("after_rst_vld", out_valid, 1'b1);
    chk("after_rst_x", x, 8'hE8);
    tick();
    chk("after_rst_drain", out_valid, 1'b0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
